// File: rtl/panel_pkg.sv
// Shared panel-level types: boundary behaviour selector for the up/down register.
package panel_pkg;

    typedef enum logic {
        CTR_WRAP = 1'b0,
        CTR_SAT  = 1'b1
    } ctr_mode_t;

endpackage : panel_pkg

// File: rtl/up_down_reg.sv
// Up/down register with clear, clamped parallel load, wrap or saturate at the
// boundaries, and a registered terminal-count pulse.
module up_down_reg
    import panel_pkg::*;
#(
    parameter int              N    = 8,
    parameter logic [N-1:0]    MAX  = {N{1'b1}},
    parameter ctr_mode_t       MODE = CTR_WRAP
) (
    input  logic           STCP,
    input  logic           rst,
    input  logic           clr,
    input  logic           load,
    input  logic [N-1:0]   d,
    input  logic           inc,
    input  logic           dec,
    output logic [N-1:0]   q,
    output logic           at_max,
    output logic           at_zero,
    output logic           tc
);

    logic [N-1:0] r_q;
    logic         r_tc;
    logic [N-1:0] w_nxt_q;
    logic         w_nxt_tc;

    // Out-of-range load values are pulled down to MAX so q never leaves 0..MAX.
    function automatic logic [N-1:0] clamp_to_max(input logic [N-1:0] val);
        return (val > MAX) ? MAX : val;
    endfunction

    always_comb begin
        w_nxt_q  = r_q;
        w_nxt_tc = 1'b0;
        if (clr) begin
            w_nxt_q = '0;
        end else if (load) begin
            w_nxt_q = clamp_to_max(d);
        end else if (inc && !dec) begin
            if (r_q >= MAX) begin
                w_nxt_tc = 1'b1;
                w_nxt_q  = (MODE == CTR_WRAP) ? '0 : MAX;
            end else begin
                w_nxt_q = r_q + 1'b1;
            end
        end else if (dec && !inc) begin
            if (r_q == '0) begin
                w_nxt_tc = 1'b1;
                w_nxt_q  = (MODE == CTR_WRAP) ? MAX : '0;
            end else begin
                w_nxt_q = r_q - 1'b1;
            end
        end
    end

    always_ff @(posedge STCP or posedge rst) begin
        if (rst) begin
            r_q  <= '0;
            r_tc <= 1'b0;
        end else begin
            r_q  <= w_nxt_q;
            r_tc <= w_nxt_tc;
        end
    end

    assign q       = r_q;
    assign tc      = r_tc;
    assign at_max  = (r_q == MAX);
    assign at_zero = (r_q == '0);

endmodule : up_down_reg

// File: tb/tb_up_down_reg.sv
// Directed bench for up_down_reg: wrap and saturate variants at N=4/MAX=9,
// plus the default 8-bit wrap configuration.
module tb_up_down_reg;
    import panel_pkg::*;

    logic STCP;
    logic rst;

    logic       w_clr, w_load, w_inc, w_dec;
    logic [3:0] w_d;
    logic [3:0] w_q;
    logic       w_at_max, w_at_zero, w_tc;

    logic       s_clr, s_load, s_inc, s_dec;
    logic [3:0] s_d;
    logic [3:0] s_q;
    logic       s_at_max, s_at_zero, s_tc;

    logic       g_clr, g_load, g_inc, g_dec;
    logic [7:0] g_d;
    logic [7:0] g_q;
    logic       g_at_max, g_at_zero, g_tc;

    int checks = 0;
    int errors = 0;
    int tc_pulses;

    up_down_reg #(.N(4), .MAX(4'd9), .MODE(CTR_WRAP)) u_wrap (
        .STCP(STCP), .rst(rst), .clr(w_clr), .load(w_load), .d(w_d),
        .inc(w_inc), .dec(w_dec), .q(w_q), .at_max(w_at_max),
        .at_zero(w_at_zero), .tc(w_tc)
    );

    up_down_reg #(.N(4), .MAX(4'd9), .MODE(CTR_SAT)) u_sat (
        .STCP(STCP), .rst(rst), .clr(s_clr), .load(s_load), .d(s_d),
        .inc(s_inc), .dec(s_dec), .q(s_q), .at_max(s_at_max),
        .at_zero(s_at_zero), .tc(s_tc)
    );

    up_down_reg u_def (
        .STCP(STCP), .rst(rst), .clr(g_clr), .load(g_load), .d(g_d),
        .inc(g_inc), .dec(g_dec), .q(g_q), .at_max(g_at_max),
        .at_zero(g_at_zero), .tc(g_tc)
    );

    initial STCP = 1'b0;
    always #5 STCP = ~STCP;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge STCP);
        #1;
    endtask

    task automatic drv_w(input logic c, input logic l, input logic [3:0] dv,
                         input logic i, input logic dd);
        w_clr = c; w_load = l; w_d = dv; w_inc = i; w_dec = dd;
    endtask

    task automatic drv_s(input logic c, input logic l, input logic [3:0] dv,
                         input logic i, input logic dd);
        s_clr = c; s_load = l; s_d = dv; s_inc = i; s_dec = dd;
    endtask

    initial begin
        rst = 1'b1;
        drv_w(0, 0, 4'd0, 0, 0);
        drv_s(0, 0, 4'd0, 0, 0);
        g_clr = 0; g_load = 0; g_d = 8'd0; g_inc = 0; g_dec = 0;
        #2;
        chk("rst_q", 32'(w_q), 0);
        chk("rst_tc", 32'(w_tc), 0);
        chk("rst_at_zero", 32'(w_at_zero), 1);
        chk("rst_at_max", 32'(w_at_max), 0);

        // Commands ignored while reset is held across an edge.
        drv_w(0, 1, 4'd7, 1, 0);
        tick();
        chk("rst_ignore_q", 32'(w_q), 0);
        chk("rst_ignore_tc", 32'(w_tc), 0);
        drv_w(0, 0, 4'd0, 0, 0);
        rst = 1'b0;

        // Wrap: load 8, inc to 9, inc wraps to 0 with tc.
        drv_w(0, 1, 4'd8, 0, 0); tick();
        chk("w_load8_q", 32'(w_q), 8);
        chk("w_load8_tc", 32'(w_tc), 0);
        drv_w(0, 0, 4'd0, 1, 0); tick();
        chk("w_inc1_q", 32'(w_q), 9);
        chk("w_inc1_tc", 32'(w_tc), 0);
        chk("w_inc1_at_max", 32'(w_at_max), 1);
        tick();
        chk("w_inc2_q", 32'(w_q), 0);
        chk("w_inc2_tc", 32'(w_tc), 1);
        chk("w_inc2_at_zero", 32'(w_at_zero), 1);
        drv_w(0, 0, 4'd0, 0, 0); tick();
        chk("w_hold_tc", 32'(w_tc), 0);
        chk("w_hold_q", 32'(w_q), 0);
        drv_w(0, 0, 4'd0, 0, 1); tick();
        chk("w_dec0_q", 32'(w_q), 9);
        chk("w_dec0_tc", 32'(w_tc), 1);
        tick();
        chk("w_dec9_q", 32'(w_q), 8);
        chk("w_dec9_tc", 32'(w_tc), 0);

        // Priority and clamping.
        drv_w(1, 1, 4'd5, 1, 0); tick();
        chk("prio_clr_q", 32'(w_q), 0);
        chk("prio_clr_tc", 32'(w_tc), 0);
        drv_w(0, 1, 4'd12, 0, 0); tick();
        chk("clamp_q", 32'(w_q), 9);
        chk("clamp_at_max", 32'(w_at_max), 1);
        drv_w(0, 1, 4'd4, 0, 0); tick();
        chk("load4_q", 32'(w_q), 4);
        drv_w(0, 0, 4'd0, 1, 1); tick();
        chk("both_q", 32'(w_q), 4);
        chk("both_tc", 32'(w_tc), 0);

        // Asynchronous reset with a nonzero value.
        drv_w(0, 1, 4'd5, 0, 0); tick();
        chk("pre_rst_q", 32'(w_q), 5);
        drv_w(0, 0, 4'd0, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_q", 32'(w_q), 0);
        #1 rst = 1'b0;

        // Reset discards a pending tc, then the first edge counts normally.
        drv_w(0, 1, 4'd9, 0, 0); tick();
        drv_w(0, 0, 4'd0, 1, 0); tick();
        chk("pend_q", 32'(w_q), 0);
        chk("pend_tc", 32'(w_tc), 1);
        drv_w(0, 0, 4'd0, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk("pend_rst_tc", 32'(w_tc), 0);
        chk("pend_rst_q", 32'(w_q), 0);
        #1 rst = 1'b0;
        drv_w(0, 0, 4'd0, 1, 0); tick();
        chk("post_rst_q", 32'(w_q), 1);
        chk("post_rst_tc", 32'(w_tc), 0);
        drv_w(0, 0, 4'd0, 0, 0);

        // Saturate: dec at 0 holds with tc each time.
        chk("s_start_q", 32'(s_q), 0);
        drv_s(0, 0, 4'd0, 0, 1); tick();
        chk("s_dec1_q", 32'(s_q), 0);
        chk("s_dec1_tc", 32'(s_tc), 1);
        chk("s_dec1_at_zero", 32'(s_at_zero), 1);
        tick();
        chk("s_dec2_q", 32'(s_q), 0);
        chk("s_dec2_tc", 32'(s_tc), 1);
        chk("s_dec2_at_zero", 32'(s_at_zero), 1);
        drv_s(0, 1, 4'd9, 0, 0); tick();
        chk("s_load9_tc", 32'(s_tc), 0);
        drv_s(0, 0, 4'd0, 1, 0); tick();
        chk("s_incmax_q", 32'(s_q), 9);
        chk("s_incmax_tc", 32'(s_tc), 1);
        drv_s(0, 1, 4'd3, 0, 0); tick();
        drv_s(0, 0, 4'd0, 0, 1); tick();
        chk("s_dec3_q", 32'(s_q), 2);
        chk("s_dec3_tc", 32'(s_tc), 0);
        drv_s(0, 0, 4'd0, 0, 0);

        // Default 8-bit wrap: 256 increments return to 0 with one tc pulse.
        chk("g_start_q", 32'(g_q), 0);
        tc_pulses = 0;
        g_inc = 1'b1;
        for (int i = 0; i < 256; i++) begin
            tick();
            chk("g_step_tc", 32'(g_tc), (i == 255) ? 1 : 0);
            if (g_tc === 1'b1) tc_pulses++;
        end
        g_inc = 1'b0;
        chk("g_wrap_q", 32'(g_q), 0);
        chk("g_tc_pulses", 32'(tc_pulses), 1);
        g_load = 1'b1; g_d = 8'd255; tick();
        g_load = 1'b0;
        chk("g_at_max", 32'(g_at_max), 1);
        chk("g_load_q", 32'(g_q), 255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_up_down_reg

// File: doc/up_down_reg.md
UP_DOWN_REG -- requirements
Module: up_down_reg

Interface
REQ-001 Parameter N, default 8: counter/register width in bits.
REQ-002 Parameter MAX, default 2**N-1: highest legal value, 1 <= MAX <= 2**N-1.
REQ-003 Parameter MODE, default CTR_WRAP: boundary behaviour, CTR_WRAP or CTR_SAT.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-005 STCP  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 clr  input  1  synchronous clear to 0.
REQ-008 load  input  1  synchronous parallel load of d.
REQ-009 d  input  N  parallel load value.
REQ-010 inc  input  1  step up by 1.
REQ-011 dec  input  1  step down by 1.
REQ-012 q  output  N  current register value, driven directly from the flop.
REQ-013 at_max  output  1  combinational, high when q == MAX.
REQ-014 at_zero  output  1  combinational, high when q == 0.
REQ-015 tc  output  1  registered terminal-count pulse.

Function
REQ-016 Each rising STCP edge SHALL evaluate commands in priority order: clr, then load, then inc/dec.
REQ-017 clr=1 SHALL set q to 0 regardless of load/inc/dec.
REQ-018 load=1 with clr=0 SHALL set q to d when d <= MAX, otherwise to MAX (clamp).
REQ-019 inc=1 and dec=0 with no clr/load: q < MAX SHALL give q+1; q == MAX SHALL give 0 in CTR_WRAP or hold MAX in CTR_SAT.
REQ-020 dec=1 and inc=0 with no clr/load: q > 0 SHALL give q-1; q == 0 SHALL give MAX in CTR_WRAP or hold 0 in CTR_SAT.
REQ-021 inc=1 and dec=1 together, or no command, SHALL hold q unchanged.
REQ-022 tc SHALL be 1 for exactly the cycle after an edge where an inc step was applied at q == MAX, or a dec step at q == 0, in either mode.
REQ-023 tc SHALL be 0 after every other edge, including edges with clr, load, or hold.
REQ-024 Latency: q and tc SHALL reflect a command on the same rising edge that samples it, with one-cycle register latency and no combinational path from inputs to q or tc.
REQ-025 All arithmetic SHALL be N bits wide, and q SHALL never exceed MAX.

Reset
REQ-026 rst=1 SHALL immediately force q=0 and tc=0, independent of STCP.
REQ-027 While rst=1, clr/load/inc/dec SHALL be ignored.
REQ-028 Reset asserted mid-sequence SHALL discard any pending tc.
REQ-029 The first edge after rst deasserts SHALL be processed normally.

Structure
REQ-030 Enum ctr_mode_t {CTR_WRAP, CTR_SAT} SHALL live in shared package panel_pkg, and MODE SHALL be of that type.
REQ-031 The block SHALL be a single module with no sub-modules; the next-value logic SHALL be one combinational block feeding one always_ff.

Verification (N=4, MAX=9 unless stated)
REQ-032 WRAP: load d=8, then inc x2 -> q=9 then 0; tc=1 only after the second inc.
REQ-033 SAT: q=0, dec x2 -> q stays 0, tc=1 after each dec, at_zero=1 throughout.
REQ-034 Priority: clr=1, load=1, d=5, inc=1 on one edge -> q=0; next edge load=1, d=12 -> q=9 (clamped), at_max=1.
REQ-035 Simultaneous: q=4, inc=1 and dec=1 -> q=4, tc=0.
REQ-036 Reset: inc pulse with q=9 in WRAP, then rst asserted between edges -> q=0 and tc=0 immediately; after release, inc -> q=1.
REQ-037 Default parameters (N=8, MAX=255, WRAP): 256 incs from 0 -> q=0, with a single tc pulse.
